// File: rtl/bounce_seq_ctrl.sv
// bounce_seq_ctrl: command-driven sawtooth/bounce sequencer
// for a W-bit up/down counting datapath.
module bounce_seq_ctrl #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cmd_valid,
  input  logic [1:0]   i_cmd_op,
  input  logic [W-1:0] i_cmd_lo,
  input  logic [W-1:0] i_cmd_hi,
  input  logic [3:0]   i_cmd_rep,
  output logic [W-1:0] o_sa,
  output logic         o_busy,
  output logic         o_turn,
  output logic         o_done,
  output logic         o_err,
  output logic [3:0]   o_cyc
);

  typedef enum logic [2:0] {
    S_IDLE, S_UP, S_DOWN, S_HOLD_HI, S_HOLD_LO
  } state_t;

  localparam logic [1:0]   OP_STOP = 2'b00;
  localparam logic [1:0]   OP_DN   = 2'b10;
  localparam logic [1:0]   OP_BNC  = 2'b11;
  localparam logic [W-1:0] ONE     = W'(1);

  state_t       r_state;
  logic         r_bnc;
  logic [W-1:0] r_lo;
  logic [W-1:0] r_hi;
  logic [3:0]   r_rep;
  logic [W-1:0] r_sa;
  logic [3:0]   r_cyc;
  logic         r_busy;
  logic         r_turn;
  logic         r_done;
  logic         r_err;

  state_t       w_state_nxt;
  logic [W-1:0] w_sa_nxt;
  logic [3:0]   w_cyc_nxt;
  logic         w_busy_nxt;
  logic         w_turn_nxt;
  logic         w_done_nxt;
  logic         w_err_nxt;

  logic         w_stop;
  logic         w_run;
  logic         w_start;
  logic         w_rej;
  logic         w_at_hi;
  logic         w_at_lo;
  logic         w_turn;
  logic         w_period;
  logic         w_last;
  logic [4:0]   w_cyc_inc;
  logic [3:0]   w_cyc_sat;

  assign w_stop  = i_cmd_valid && (i_cmd_op == OP_STOP);
  assign w_run   = i_cmd_valid && (i_cmd_op != OP_STOP);
  assign w_start = w_run && (r_state == S_IDLE)
                && (i_cmd_lo < i_cmd_hi);
  assign w_rej   = w_run && !w_start;

  assign w_at_hi = (r_sa == r_hi);
  assign w_at_lo = (r_sa == r_lo);

  // Every turn happens at UP@hi or DOWN@lo; a period ends on
  // each wrap and on each bounce entry into HOLD_LO.
  assign w_turn   = ((r_state == S_UP) && w_at_hi)
                 || ((r_state == S_DOWN) && w_at_lo);
  assign w_period = ((r_state == S_UP) && w_at_hi && !r_bnc)
                 || ((r_state == S_DOWN) && w_at_lo);

  assign w_cyc_inc = {1'b0, r_cyc} + 5'd1;
  assign w_cyc_sat = (r_cyc == 4'hF) ? 4'hF : w_cyc_inc[3:0];
  assign w_last    = w_period && (r_rep != 4'd0)
                  && (w_cyc_inc == {1'b0, r_rep});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_bnc   <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rep   <= '0;
      r_sa    <= '0;
      r_cyc   <= '0;
      r_busy  <= 1'b0;
      r_turn  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sa    <= w_sa_nxt;
      r_cyc   <= w_cyc_nxt;
      r_busy  <= w_busy_nxt;
      r_turn  <= w_turn_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_start) begin
        r_bnc <= (i_cmd_op == OP_BNC);
        r_lo  <= i_cmd_lo;
        r_hi  <= i_cmd_hi;
        r_rep <= i_cmd_rep;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = (i_cmd_op == OP_DN) ? S_DOWN : S_UP;
    end else begin
      unique case (r_state)
        S_UP: begin
          if (w_at_hi)
            w_state_nxt = r_bnc ? S_HOLD_HI
                        : (w_last ? S_IDLE : S_UP);
        end
        S_DOWN: begin
          if (w_at_lo)
            w_state_nxt = w_last ? S_IDLE
                        : (r_bnc ? S_HOLD_LO : S_DOWN);
        end
        S_HOLD_HI: w_state_nxt = S_DOWN;
        S_HOLD_LO: w_state_nxt = S_UP;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sa_nxt   = r_sa;
    w_cyc_nxt  = r_cyc;
    w_busy_nxt = r_busy;
    w_turn_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_err_nxt  = w_rej;
    if (w_stop) begin
      w_busy_nxt = 1'b0;
    end else if (w_start) begin
      w_sa_nxt   = (i_cmd_op == OP_DN) ? i_cmd_hi : i_cmd_lo;
      w_cyc_nxt  = 4'd0;
      w_busy_nxt = 1'b1;
    end else begin
      unique case (r_state)
        S_UP:
          w_sa_nxt = w_at_hi ? (r_bnc ? r_sa : r_lo)
                   : r_sa + ONE;
        S_DOWN:
          w_sa_nxt = w_at_lo ? (r_bnc ? r_sa : r_hi)
                   : r_sa - ONE;
        S_HOLD_HI: w_sa_nxt = r_sa - ONE;
        S_HOLD_LO: w_sa_nxt = r_sa + ONE;
        default:   w_sa_nxt = r_sa;
      endcase
      w_turn_nxt = w_turn;
      if (w_period)
        w_cyc_nxt = w_cyc_sat;
      if (w_last) begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
    end
  end

  assign o_sa   = r_sa;
  assign o_busy = r_busy;
  assign o_turn = r_turn;
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_cyc  = r_cyc;

endmodule
